// File: rtl/bt_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart_pkg
// Description : Shared types and default constants for the Bluetooth-link
//               UART receiver (bt_uart_rx) and its receive FIFO.
//               - bt_rx_state_t : receiver FSM state encoding
//               - BT_CLKS_PER_BIT / BT_FIFO_DEPTH : default configuration
// Revision    : 1.0 - initial release
// ============================================================================
package bt_uart_pkg;

    // 50 MHz sclk / 115200 baud
    localparam int BT_CLKS_PER_BIT = 434;
    localparam int BT_FIFO_DEPTH   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } bt_rx_state_t;

endpackage : bt_uart_pkg
`default_nettype wire

// File: rtl/bt_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bt_rx_fifo
// Description : Synchronous byte FIFO for the UART receive path.
//               Ports : CLK, RST_N (async active-low), PUSH, POP, DIN[7:0],
//                       DOUT[7:0] (head byte, 0 when empty), COUNT, EMPTY,
//                       FULL.
//               A POP on an empty FIFO is ignored. A PUSH while full is
//               accepted only if a POP frees a slot in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   PUSH,
    input  logic                   POP,
    input  logic [7:0]             DIN,
    output logic [7:0]             DOUT,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   EMPTY,
    output logic                   FULL
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign EMPTY = (r_count == '0);
    assign FULL  = (r_count == c_depth);
    assign COUNT = r_count;
    assign DOUT  = EMPTY ? 8'h00 : r_mem[r_rd_ptr];

    // A simultaneous pop frees the slot the push needs, so a full FIFO
    // still accepts the new byte in that cycle.
    assign w_do_pop  = POP && !EMPTY;
    assign w_do_push = PUSH && (!FULL || w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= DIN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bt_rx_fifo
`default_nettype wire

// File: rtl/bt_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : bt_uart_rx
// Description : UART receiver (8N1, or 8E1 with BT_UART_RX_PARITY_EN) with
//               receive FIFO for the Bluetooth serial link.
//               Ports : CLK, RST_N (async active-low), RX (async serial in),
//                       POP, CLR_ERR (one-cycle pulses), DATA_OUT[7:0],
//                       COUNT, EMPTY, FULL, OVERRUN, FRAME_ERR (sticky),
//                       INTR (one-cycle pulse per byte stored),
//                       PARITY_ERR (sticky, only with BT_UART_RX_PARITY_EN).
//               Optional macro : BT_UART_RX_PARITY_EN (even parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module bt_uart_rx
    import bt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BT_CLKS_PER_BIT,
    parameter int DEPTH        = BT_FIFO_DEPTH
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   RX,
    input  logic                   POP,
    input  logic                   CLR_ERR,
    output logic [7:0]             DATA_OUT,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   OVERRUN,
    output logic                   FRAME_ERR,
    output logic                   INTR
`ifdef BT_UART_RX_PARITY_EN
    ,
    output logic                   PARITY_ERR
`endif
);

    localparam int                 c_cnt_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    // Synchronizer: meta -> sync, plus prev for falling-edge detection.
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    bt_rx_state_t        r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_intr;
    logic                r_overrun;
    logic                r_frame_err;

    logic w_bit_done;
    logic w_stop_sample;
    logic w_stop_ok;
    logic w_push;
    logic w_overrun_set;
    logic w_frame_set;

`ifdef BT_UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_parity_set;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parity_set = (r_state == PARITY) && w_bit_done &&
                          (^{r_shift, r_rx_sync});
    assign w_stop_ok    = w_stop_sample && r_rx_sync && !r_par_bad;
    assign PARITY_ERR   = r_parity_err;
`else
    assign w_stop_ok    = w_stop_sample && r_rx_sync;
`endif

    assign w_bit_done    = (r_cnt == c_bit_last);
    assign w_stop_sample = (r_state == STOP) && w_bit_done;
    assign w_frame_set   = w_stop_sample && !r_rx_sync;
    // A POP in the stop-sample cycle makes room, so the byte is kept.
    assign w_push        = w_stop_ok && (!FULL || POP);
    assign w_overrun_set = w_stop_ok && FULL && !POP;

    assign INTR      = r_intr;
    assign OVERRUN   = r_overrun;
    assign FRAME_ERR = r_frame_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef BT_UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Edge-triggered so a held-low break cannot retrigger.
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
`ifdef BT_UART_RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef BT_UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
`ifdef BT_UART_RX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_par_bad <= w_parity_set;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as CLR_ERR takes priority.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_intr       <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef BT_UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_intr <= w_push;
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (CLR_ERR) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (CLR_ERR) begin
                r_frame_err <= 1'b0;
            end
`ifdef BT_UART_RX_PARITY_EN
            if (w_parity_set) begin
                r_parity_err <= 1'b1;
            end else if (CLR_ERR) begin
                r_parity_err <= 1'b0;
            end
`endif
        end
    end

    bt_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .PUSH  (w_push),
        .POP   (POP),
        .DIN   (r_shift),
        .DOUT  (DATA_OUT),
        .COUNT (COUNT),
        .EMPTY (EMPTY),
        .FULL  (FULL)
    );

endmodule : bt_uart_rx
`default_nettype wire
